// File: rtl/screen_pkg.sv
// Shared constants and types for the screen memory response path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package screen_pkg;

    localparam int SCR_DW         = 16;  // pixel data word width
    localparam int SCR_AW         = 20;  // read address width (base + local bits)
    localparam int SCR_RESP_DEPTH = 4;   // return-buffer entries, power of two

    typedef logic [SCR_DW-1:0] pixel_t;

endpackage

// File: rtl/screen_resp_fifo.sv
// Return-data buffer: FIFO-ordered storage with a registered occupancy count.
// Latency: push visible at head one cycle later; head is a combinational read.
// Backpressure: push while full and pop while empty are ignored; count/pointers unchanged.
//
// Ports: clk, rst (async, active-high); push/push_dat write the tail;
//        pop retires the head; head is the oldest entry; full, empty, count.
module screen_resp_fifo
    import screen_pkg::*;
#(
    parameter int DW    = SCR_DW,
    parameter int DEPTH = SCR_RESP_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/screen_mem_resp.sv
// Read responder: grants addresses against buffer credits, drives a sync RAM, queues returns.
// Latency: address accepted in T -> RAM read in T -> data at mem_dat in T+2 (minimum).
// Backpressure: credit based; grant drops when buffered + in-flight reaches DEPTH or RAM is busy.
//
// Ports: clk, rst (async, active-high);
//        mem_addr_vld/mem_addr_gnt/mem_addr   request address channel;
//        mem_dat_vld/mem_dat_gnt/mem_dat      return data channel;
//        ram_busy, ram_rd_en, ram_addr, ram_rd_dat  synchronous RAM read port.
module screen_mem_resp
    import screen_pkg::*;
#(
    parameter int DW    = SCR_DW,
    parameter int AW    = SCR_AW,
    parameter int DEPTH = SCR_RESP_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_addr_vld,
    output logic          mem_addr_gnt,
    input  logic [AW-1:0] mem_addr,
    output logic          mem_dat_vld,
    input  logic          mem_dat_gnt,
    output logic [DW-1:0] mem_dat,
    input  logic          ram_busy,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rd_dat
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_flight;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;
    logic [DW-1:0] buf_head;
    logic [CW:0]   occ;

    // A read in flight has already claimed a buffer slot, so it counts as a credit in use.
    assign occ = {1'b0, buf_count} + {{CW{1'b0}}, in_flight};

    // Grant never looks at mem_addr_vld, so the requester may use it to decide.
    // occ < DEPTH already implies !buf_full; the full term guards the buffer directly.
    assign mem_addr_gnt = !rst && !ram_busy && !buf_full && (occ < (CW+1)'(DEPTH));
    assign ram_rd_en    = mem_addr_vld && mem_addr_gnt;
    assign ram_addr     = mem_addr;

    // RAM data lands one cycle after the strobe; busy does not abort it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_flight <= 1'b0;
        else     in_flight <= ram_rd_en;
    end

    screen_resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_flight),
        .push_dat (ram_rd_dat),
        .pop      (mem_dat_gnt),
        .head     (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    assign mem_dat_vld = !buf_empty;
    // Zero when empty so stale storage never appears on the bus (including during reset).
    assign mem_dat     = buf_empty ? '0 : buf_head;

endmodule

// File: tb/tb_screen_mem_resp.sv
// Self-checking bench for screen_mem_resp: directed scenarios plus random traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_screen_mem_resp;
    import screen_pkg::*;

    localparam int DW    = SCR_DW;
    localparam int AW    = SCR_AW;
    localparam int DEPTH = SCR_RESP_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_addr_vld;
    logic          mem_addr_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_dat_vld;
    logic          mem_dat_gnt;
    logic [DW-1:0] mem_dat;
    logic          ram_busy;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rd_dat;

    screen_mem_resp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr_vld (mem_addr_vld),
        .mem_addr_gnt (mem_addr_gnt),
        .mem_addr     (mem_addr),
        .mem_dat_vld  (mem_dat_vld),
        .mem_dat_gnt  (mem_dat_gnt),
        .mem_dat      (mem_dat),
        .ram_busy     (ram_busy),
        .ram_rd_en    (ram_rd_en),
        .ram_addr     (ram_addr),
        .ram_rd_dat   (ram_rd_dat)
    );

    always #5 clk = ~clk;

    // Synchronous RAM image, indexed by the low address byte.
    logic [DW-1:0] ram_img [256];
    logic [AW-1:0] rd_addr_q;
    always @(posedge clk) rd_addr_q <= ram_addr;
    always_comb ram_rd_dat = ram_img[rd_addr_q[7:0]];

    // Reference model: list of accepted reads not yet returned, with acceptance cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } txn_t;
    txn_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_fail;

    // A slot is held from acceptance until the cycle after it is returned.
    function automatic logic exp_gnt();
        return !rst && !ram_busy && (q.size() < DEPTH);
    endfunction

    // Data is visible two cycles after its address was accepted.
    function automatic logic exp_vld();
        return (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    endfunction

    function automatic logic [DW-1:0] exp_dat();
        return (q.size() > 0) ? q[0].data : '0;
    endfunction

    // Advance one clock and update the model from the transfers of this cycle.
    task automatic tick();
        logic acc;
        logic pop;
        txn_t t;
        acc = mem_addr_vld && exp_gnt();
        pop = exp_vld() && mem_dat_gnt;
        t.data = ram_img[mem_addr[7:0]];
        t.cyc  = cyc;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(t);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        mem_addr_vld = 1'b0;
        ram_busy     = 1'b0;
        mem_dat_gnt  = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 4; i++) tick();
        mem_dat_gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_addr_vld = 1'b1; mem_addr = 20'h00055; ram_busy = 1'b0; mem_dat_gnt = 1'b1;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b want=0", mem_addr_gnt); end
        n_cmp++; if (ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", ram_rd_en); end
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dat_vld got=%b want=0", mem_dat_vld); end
        n_cmp++; if (mem_dat !== '0) begin n_fail++; $display("FAIL reset_dat got=%h want=0", mem_dat); end
        tick(); tick();
        rst = 1'b0; mem_addr_vld = 1'b0; mem_dat_gnt = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ram_img[8'h10] = 16'hA5A5;
        mem_addr = 20'h00010; mem_addr_vld = 1'b1; mem_dat_gnt = 1'b0;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt got=%b want=1", mem_addr_gnt); end
        n_cmp++; if (ram_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en got=%b want=1", ram_rd_en); end
        n_cmp++; if (ram_addr !== 20'h00010) begin n_fail++; $display("FAIL single_ram_addr got=%h want=00010", ram_addr); end
        tick();
        mem_addr_vld = 1'b0;
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL single_t1_vld got=%b want=0", mem_dat_vld); end
        tick();
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b1) begin n_fail++; $display("FAIL single_t2_vld got=%b want=1", mem_dat_vld); end
        n_cmp++; if (mem_dat !== 16'hA5A5) begin n_fail++; $display("FAIL single_t2_dat got=%h want=a5a5", mem_dat); end
        mem_dat_gnt = 1'b1;
        tick();
        mem_dat_gnt = 1'b0;
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b want=0", mem_dat_vld); end
        tick();
    endtask

    task automatic test_back_to_back();
        int npop;
        npop = 0;
        mem_dat_gnt = 1'b1; ram_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_addr_vld = (i < 8);
            mem_addr     = AW'(i);
            #2;
            if (i < 8) begin
                n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt cyc=%0d got=%b want=1", i, mem_addr_gnt); end
            end
            n_cmp++; if (mem_dat_vld !== exp_vld()) begin n_fail++; $display("FAIL b2b_vld cyc=%0d got=%b want=%b", i, mem_dat_vld, exp_vld()); end
            if (exp_vld()) begin
                npop++;
                n_cmp++; if (mem_dat !== exp_dat()) begin n_fail++; $display("FAIL b2b_dat cyc=%0d got=%h want=%h", i, mem_dat, exp_dat()); end
            end
            tick();
        end
        n_cmp++; if (npop !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", npop); end
        drain();
    endtask

    task automatic test_backpressure();
        int            granted;
        logic          have_head;
        logic [DW-1:0] head_val;
        granted = 0; have_head = 1'b0; head_val = '0;
        mem_dat_gnt = 1'b0; ram_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_addr_vld = (granted < 6);
            mem_addr     = AW'(20'h00100 + granted);
            #2;
            n_cmp++; if (mem_addr_gnt !== exp_gnt()) begin n_fail++; $display("FAIL bp_gnt cyc=%0d got=%b want=%b", i, mem_addr_gnt, exp_gnt()); end
            if (mem_addr_vld && mem_addr_gnt) granted++;
            if (mem_dat_vld) begin
                if (!have_head) begin
                    head_val = exp_dat(); have_head = 1'b1;
                end
                n_cmp++; if (mem_dat !== head_val) begin n_fail++; $display("FAIL bp_head_stable cyc=%0d got=%h want=%h", i, mem_dat, head_val); end
            end
            tick();
        end
        n_cmp++; if (granted !== DEPTH) begin n_fail++; $display("FAIL bp_granted got=%0d want=%0d", granted, DEPTH); end
        mem_dat_gnt = 1'b1;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b0) begin n_fail++; $display("FAIL bp_gnt_pop_cycle got=%b want=0", mem_addr_gnt); end
        tick();
        mem_dat_gnt = 1'b0;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL bp_gnt_after_pop got=%b want=1", mem_addr_gnt); end
        tick();
        drain();
    endtask

    task automatic test_arbitration();
        mem_addr_vld = 1'b1; mem_addr = 20'h00042; ram_busy = 1'b1; mem_dat_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (mem_addr_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_gnt_busy cyc=%0d got=%b want=0", i, mem_addr_gnt); end
            n_cmp++; if (ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL arb_rd_en_busy cyc=%0d got=%b want=0", i, ram_rd_en); end
            tick();
        end
        ram_busy = 1'b0;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL arb_gnt_free got=%b want=1", mem_addr_gnt); end
        n_cmp++; if (ram_rd_en !== 1'b1) begin n_fail++; $display("FAIL arb_rd_en_free got=%b want=1", ram_rd_en); end
        tick();
        mem_addr_vld = 1'b0;
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL arb_t1_vld got=%b want=0", mem_dat_vld); end
        tick();
        #2;
        n_cmp++; if (mem_dat !== exp_dat() || mem_dat_vld !== 1'b1) begin n_fail++; $display("FAIL arb_dat got=%b/%h want=1/%h", mem_dat_vld, mem_dat, exp_dat()); end
        drain();
    endtask

    task automatic test_push_pop_wrap();
        ram_busy = 1'b0; mem_dat_gnt = 1'b0;
        for (int i = 0; i < 12 + 6; i++) begin
            mem_addr_vld = (i < 12);
            mem_addr     = AW'(20'h00200 + i);
            mem_dat_gnt  = (i >= 3);
            #2;
            if (i >= 3 && i < 12) begin
                n_cmp++; if (dut.u_fifo.count !== 3'd2) begin n_fail++; $display("FAIL pp_count cyc=%0d got=%0d want=2", i, dut.u_fifo.count); end
            end
            if (i < 12) begin
                n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL pp_gnt cyc=%0d got=%b want=1", i, mem_addr_gnt); end
            end
            n_cmp++; if (mem_dat_vld !== exp_vld()) begin n_fail++; $display("FAIL pp_vld cyc=%0d got=%b want=%b", i, mem_dat_vld, exp_vld()); end
            if (exp_vld()) begin
                n_cmp++; if (mem_dat !== exp_dat()) begin n_fail++; $display("FAIL pp_order cyc=%0d got=%h want=%h", i, mem_dat, exp_dat()); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        ram_busy = 1'b0; mem_dat_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_addr_vld = 1'b1; mem_addr = AW'(20'h00300 + i);
            tick();
        end
        mem_addr_vld = 1'b0;
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_vld got=%b want=1", mem_dat_vld); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_vld got=%b want=0", mem_dat_vld); end
        n_cmp++; if (mem_addr_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt got=%b want=0", mem_addr_gnt); end
        tick();
        rst = 1'b0;
        ram_img[8'h77] = DW'($urandom());
        mem_addr_vld = 1'b1; mem_addr = 20'h00377;
        #2;
        n_cmp++; if (mem_addr_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_new_gnt got=%b want=1", mem_addr_gnt); end
        tick();
        mem_addr_vld = 1'b0;
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_t1_vld got=%b want=0", mem_dat_vld); end
        tick();
        #2;
        n_cmp++; if (mem_dat_vld !== 1'b1) begin n_fail++; $display("FAIL rmid_t2_vld got=%b want=1", mem_dat_vld); end
        n_cmp++; if (mem_dat !== ram_img[8'h77]) begin n_fail++; $display("FAIL rmid_t2_dat got=%h want=%h", mem_dat, ram_img[8'h77]); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mem_addr_vld = ($urandom_range(0, 3) != 0);
            ram_busy     = ($urandom_range(0, 4) == 0);
            mem_dat_gnt  = ($urandom_range(0, 2) != 0);
            mem_addr     = AW'($urandom());
            #2;
            n_cmp++; if (mem_addr_gnt !== exp_gnt()) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", i, mem_addr_gnt, exp_gnt()); end
            n_cmp++; if (ram_rd_en !== (mem_addr_vld && exp_gnt())) begin n_fail++; $display("FAIL rnd_rd_en cyc=%0d got=%b want=%b", i, ram_rd_en, mem_addr_vld && exp_gnt()); end
            n_cmp++; if (ram_addr !== mem_addr) begin n_fail++; $display("FAIL rnd_ram_addr cyc=%0d got=%h want=%h", i, ram_addr, mem_addr); end
            n_cmp++; if (mem_dat_vld !== exp_vld()) begin n_fail++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", i, mem_dat_vld, exp_vld()); end
            if (exp_vld()) begin
                n_cmp++; if (mem_dat !== exp_dat()) begin n_fail++; $display("FAIL rnd_dat cyc=%0d got=%h want=%h", i, mem_dat, exp_dat()); end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; mem_addr_vld = 1'b0; mem_addr = '0; mem_dat_gnt = 1'b0; ram_busy = 1'b0;
        for (int i = 0; i < 256; i++) ram_img[i] = DW'($urandom());
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_arbitration();
        test_push_pop_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_mem_resp.md
SCREEN_MEM_RESP -- requirements
Module: screen_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 16, pixel data word width.
- AW, 20, request address width (base bits plus local bits).
- DEPTH, 4, return-buffer entries; power of two, at least 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- mem_addr_vld, in, 1, requester presents a read address.
- mem_addr_gnt, out, 1, responder accepts the address.
- mem_addr, in, AW, word address of the read.
- mem_dat_vld, out, 1, return data available.
- mem_dat_gnt, in, 1, requester accepts the return data.
- mem_dat, out, DW, return data word.
- ram_busy, in, 1, RAM port owned by another master this cycle.
- ram_rd_en, out, 1, synchronous RAM read strobe.
- ram_addr, out, AW, RAM read address.
- ram_rd_dat, in, DW, RAM read data, valid one cycle after ram_rd_en.

REQ-003 One clock; reset asynchronous, active-high, on port rst.

Function
REQ-004 A transfer on either channel SHALL occur only in a cycle where vld and gnt are both 1.
REQ-005 mem_addr_gnt SHALL equal !ram_busy && (occ < DEPTH), where occ = buffer count + in-flight flag; it SHALL NOT depend on mem_addr_vld.
REQ-006 ram_rd_en SHALL equal mem_addr_vld && mem_addr_gnt combinationally, and ram_addr SHALL equal mem_addr.
REQ-007 An in-flight flag SHALL set on an address transfer and clear one cycle later; in that later cycle ram_rd_dat SHALL be written into the buffer tail.
REQ-008 Minimum latency SHALL be: address transfer in cycle T, mem_dat_vld = 1 with that data in cycle T+2.
REQ-009 The buffer SHALL be FIFO-ordered; return data order SHALL equal address acceptance order.
REQ-010 mem_dat_vld SHALL equal buffer-not-empty; mem_dat SHALL be the head entry, held stable while mem_dat_vld && !mem_dat_gnt.
REQ-011 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-012 Credit rule: the buffer SHALL never overflow; with DEPTH entries outstanding, mem_addr_gnt = 0 until a pop.
REQ-013 A pop in cycle C SHALL free a credit visible to mem_addr_gnt in cycle C+1 (registered count).
REQ-014 ram_busy SHALL block only new grants; an in-flight read SHALL still complete.
REQ-015 Pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.
REQ-016 mem_dat_gnt with an empty buffer SHALL be ignored: no pointer change.

Reset
REQ-017 On rst: buffer empty, pointers 0, in-flight flag 0, mem_dat_vld = 0, mem_dat = 0.
REQ-018 mem_addr_gnt = 0 and ram_rd_en = 0 SHALL hold while rst is asserted.
REQ-019 Reset mid-operation SHALL discard buffered and in-flight data; the first request after release SHALL see latency T+2 again.

Structure
REQ-020 Package screen_pkg SHALL hold SCR_DW, SCR_AW and SCR_RESP_DEPTH constants, plus a typedef for the DW-wide pixel word.
REQ-021 The buffer SHALL be a sub-module screen_resp_fifo with push, pop, full, empty, count and head ports; credit and RAM control stay in the top level.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single read: address 0x00010 in T, RAM returns 0xA5A5 in T+1 -> mem_dat_vld = 1 with mem_dat = 0xA5A5 in T+2; pop leaves the buffer empty.
- Back-to-back: 8 addresses 0..7, mem_dat_gnt tied to 1 -> gnt = 1 every cycle, 8 data in order, throughput 1 per cycle.
- Backpressure: DEPTH = 4, mem_dat_gnt = 0, 6 requests -> exactly 4 granted, then gnt = 0; head data stable; first pop -> gnt = 1 on the next cycle.
- Arbitration: ram_busy = 1 for 3 cycles with vld held -> gnt = 0 and ram_rd_en = 0 for 3 cycles; grant in the 4th cycle.
- Simultaneous push/pop at count 2 -> count remains 2; ordering preserved across pointer wrap (12 requests, DEPTH = 4).
- Reset with 3 entries buffered and 1 in flight -> mem_dat_vld = 0 immediately; after release a new request returns at T+2 with correct data.
